// File: rtl/ex_div.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU inside the EX stage.
// Produces one quotient bit per cycle and returns the result with its rd.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start_i      request a division (sampled only in IDLE)
//   op_i         funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i   rs1 value
//   divisor_i    rs2 value
//   waddr_i      rd of the divide instruction
//   flush_i      abort the current operation
//   busy_o       divider occupied; EX stalls
//   ready_o      one-cycle pulse; result_o/waddr_o valid (both 0 otherwise)
//   result_o     quotient or remainder
//   waddr_o      latched rd
module ex_div #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [REG_ADDR_W-1:0] waddr_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CALC  = 2'd2,
        END   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;          // bit1: remainder, bit0: unsigned
    logic [DATA_W-1:0]     dvd_q, dvd_d;        // dividend, shifted left as bits are consumed
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  div_zero_q, div_zero_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  busy_d, ready_d;
    logic [DATA_W-1:0]     result_d;
    logic [REG_ADDR_W-1:0] waddr_out_d;

    // Working values for the current cycle
    logic                  is_signed;
    logic [DATA_W:0]       rem_shift;   // one extra bit: partial remainder can exceed DATA_W bits before subtract
    logic [DATA_W:0]       rem_sub;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            waddr_q    <= '0;
            div_zero_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
            waddr_o    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            div_zero_q <= div_zero_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            busy_o     <= busy_d;
            ready_o    <= ready_d;
            result_o   <= result_d;
            waddr_o    <= waddr_out_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        div_zero_d  = div_zero_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        busy_d      = busy_o;
        ready_d     = 1'b0;
        result_d    = '0;
        waddr_out_d = '0;

        is_signed = ~op_q[0];
        rem_shift = {rem_q, dvd_q[DATA_W-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        quo_fix   = neg_quo_q ? DATA_W'(-quo_q) : quo_q;
        rem_fix   = neg_rem_q ? DATA_W'(-rem_q) : rem_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i && !flush_i && op_i[2]) begin
                    op_d    = op_i[1:0];
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    waddr_d = waddr_i;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end

            START: begin
                if (dvs_q == '0) begin
                    // Divide by zero: raw results, no sign correction
                    div_zero_d = 1'b1;
                    quo_d      = '1;
                    rem_d      = dvd_q;
                    state_d    = END;
                end else begin
                    div_zero_d = 1'b0;
                    neg_quo_d  = is_signed & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
                    neg_rem_d  = is_signed & dvd_q[DATA_W-1];
                    dvd_d      = (is_signed && dvd_q[DATA_W-1]) ? DATA_W'(-dvd_q) : dvd_q;
                    dvs_d      = (is_signed && dvs_q[DATA_W-1]) ? DATA_W'(-dvs_q) : dvs_q;
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end

            CALC: begin
                // Restoring step: bring in next dividend bit, subtract if it fits
                if (!rem_sub[DATA_W]) begin
                    rem_d = DATA_W'(rem_sub);
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = DATA_W'(rem_shift);
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = END;
                end
            end

            END: begin
                if (div_zero_q) begin
                    result_d = op_q[1] ? rem_q : quo_q;
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end
                ready_d     = 1'b1;
                waddr_out_d = waddr_q;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Flush aborts from any state; nothing reported
        if (flush_i) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            ready_d     = 1'b0;
            result_d    = '0;
            waddr_out_d = '0;
        end
    end

endmodule
